// File: rtl/conv_pe_mac.sv
// Convolution PE multiply-accumulate: LANES signed products per beat, summed into a wrapping accumulator.
// Optional macro CONV_PE_RELU_EN clamps negative results to zero on o_psum.
module conv_pe_mac #(
  parameter int W_DATA    = 8,
  parameter int LANES     = 4,
  parameter int W_ACC     = 32,
  parameter int W_CHANNEL = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      c_ctrl_data_run,
  input  logic                      c_kmode,
  input  logic [W_CHANNEL-1:0]      c_chn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*W_DATA-1:0]   in_ifm,
  input  logic [LANES*W_DATA-1:0]   in_wgt,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [W_ACC-1:0]          o_psum,
  output logic                      o_busy,
  output logic                      o_done
);

  // Nine taps per channel group need four extra bits of beat count
  localparam int W_BEAT = W_CHANNEL + 4;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_e;

  state_e                     state_q;
  logic [W_BEAT-1:0]          total_q;
  logic [W_BEAT-1:0]          count_q;
  logic                       s1Valid_q;
  logic signed [2*W_DATA-1:0] prod_q [LANES];
  logic signed [2*W_DATA-1:0] prod_d [LANES];
  logic signed [W_ACC-1:0]    acc_q;
  logic signed [W_ACC-1:0]    laneSum_d;
  logic [W_ACC-1:0]           psum_q;
  logic [W_ACC-1:0]           psum_d;
  logic [W_BEAT-1:0]          total_d;
  logic                       beatFire;
  logic                       startOk;

  assign in_ready = (state_q == ACC) && (count_q < total_q);
  assign beatFire = in_valid && in_ready;
  assign o_valid  = (state_q == OUT);
  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == OUT) && o_ready;
  assign o_psum   = psum_q;
  assign startOk  = c_ctrl_data_run && (c_chn != '0);
  assign total_d  = W_BEAT'(c_chn) * (c_kmode ? W_BEAT'(9) : W_BEAT'(1));

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = (2*W_DATA)'($signed(in_ifm[i*W_DATA +: W_DATA])) *
                  (2*W_DATA)'($signed(in_wgt[i*W_DATA +: W_DATA]));
    end
  end

  always_comb begin
    laneSum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      laneSum_d = laneSum_d + W_ACC'(prod_q[i]);
    end
  end

  always_comb begin
    psum_d = acc_q;
`ifdef CONV_PE_RELU_EN
    if (acc_q[W_ACC-1]) psum_d = '0;
`endif
  end

  // DRAIN waits for stage 1 to empty, at which point the accumulator holds the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      total_q   <= '0;
      count_q   <= '0;
      s1Valid_q <= 1'b0;
      acc_q     <= '0;
      psum_q    <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      s1Valid_q <= beatFire;
      if (beatFire) begin
        prod_q  <= prod_d;
        count_q <= count_q + W_BEAT'(1);
      end
      if (s1Valid_q) acc_q <= acc_q + laneSum_d;

      case (state_q)
        IDLE: begin
          if (startOk) begin
            state_q <= ACC;
            total_q <= total_d;
            count_q <= '0;
            acc_q   <= '0;
          end
        end
        ACC: begin
          if (beatFire && (count_q == total_q - W_BEAT'(1))) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!s1Valid_q) begin
            state_q <= OUT;
            psum_q  <= psum_d;
          end
        end
        OUT: begin
          if (o_ready) begin
            state_q <= IDLE;
            psum_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pe_mac.sv
// Testbench for conv_pe_mac: constant-data vector table, corner sequences and random jobs
// scored against a plain sum-of-products model.
module tb_conv_pe_mac;

  localparam int W_DATA    = 8;
  localparam int LANES     = 4;
  localparam int W_ACC     = 32;
  localparam int W_CHANNEL = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    run;
  logic                    kmode;
  logic [W_CHANNEL-1:0]    chn;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*W_DATA-1:0] in_ifm;
  logic [LANES*W_DATA-1:0] in_wgt;
  logic                    o_valid;
  logic                    o_ready;
  logic [W_ACC-1:0]        o_psum;
  logic                    o_busy;
  logic                    o_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit     kmode;
    int     chn;
    int     ifmVal;
    int     wgtVal;
    int     hold;
    int     gapPct;
    longint expRaw;
  } vec_t;

  vec_t vecs[6];

  conv_pe_mac #(
    .W_DATA(W_DATA), .LANES(LANES), .W_ACC(W_ACC), .W_CHANNEL(W_CHANNEL)
  ) dut (
    .clk(clk), .rst(rst), .c_ctrl_data_run(run), .c_kmode(kmode), .c_chn(chn),
    .in_valid(in_valid), .in_ready(in_ready), .in_ifm(in_ifm), .in_wgt(in_wgt),
    .o_valid(o_valid), .o_ready(o_ready), .o_psum(o_psum), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Result as the output port should present it: wrapped to W_ACC bits, clamped when ReLU is built in
  function automatic logic [W_ACC-1:0] expectPsum(input longint raw);
    logic [63:0]      r;
    logic [W_ACC-1:0] w;
    r = raw;
    w = r[W_ACC-1:0];
`ifdef CONV_PE_RELU_EN
    if (w[W_ACC-1]) w = '0;
`endif
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulseReset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  // Runs one job: start, feed N beats with optional gaps, check result timing, hold and release
  task automatic applyStimulus(input bit km, input int ch, input bit randData,
                               input int ifmVal, input int wgtVal, input int hold,
                               input int gapPct, input int midStart, input bit useExp,
                               input longint expRaw, input string name);
    int               n;
    int               sent;
    int               cyc;
    bit               fire;
    longint           sum;
    logic [7:0]       b;
    logic [W_ACC-1:0] exp;
    logic [W_ACC-1:0] held;
    logic [31:0]      chv;
    n    = (km ? 9 : 1) * ch;
    sum  = 0;
    sent = 0;
    cyc  = 0;
    chv  = ch;
    run   = 1'b1;
    kmode = km;
    chn   = chv[W_CHANNEL-1:0];
    tick();
    run = 1'b0;
    checkOutput({name, "/busy"}, o_busy, 1);
    while (sent < n && cyc < n * 4 + 50) begin
      in_valid = ($urandom_range(99) >= gapPct);
      for (int l = 0; l < LANES; l++) begin
        b = randData ? 8'($urandom_range(255)) : 8'(ifmVal);
        in_ifm[l*W_DATA +: W_DATA] = b;
        b = randData ? 8'($urandom_range(255)) : 8'(wgtVal);
        in_wgt[l*W_DATA +: W_DATA] = b;
      end
      if (sent == midStart) begin
        run   = 1'b1;
        chn   = 8'd3;
        kmode = ~km;
      end
      fire = in_valid && in_ready;
      tick();
      cyc++;
      run = 1'b0;
      if (fire) begin
        for (int l = 0; l < LANES; l++) begin
          sum += longint'($signed(in_ifm[l*W_DATA +: W_DATA])) *
                 longint'($signed(in_wgt[l*W_DATA +: W_DATA]));
        end
        sent++;
      end
    end
    in_valid = 1'b0;
    if (sent != n) begin
      checkOutput({name, "/beats"}, sent, n);
      pulseReset();
      return;
    end
    checkOutput({name, "/in_ready_drop"}, in_ready, 0);
    checkOutput({name, "/valid_t1"}, o_valid, 0);
    tick();
    checkOutput({name, "/valid_t2"}, o_valid, 0);
    tick();
    checkOutput({name, "/valid_t3"}, o_valid, 1);
    exp = useExp ? expectPsum(expRaw) : expectPsum(sum);
    checkOutput({name, "/psum"}, o_psum, exp);
    held = exp;
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput({name, "/hold_valid"}, o_valid, 1);
      checkOutput({name, "/hold_psum"}, o_psum, held);
      checkOutput({name, "/hold_done"}, o_done, 0);
      checkOutput({name, "/hold_ready"}, in_ready, 0);
    end
    o_ready = 1'b1;
    #1;
    checkOutput({name, "/done"}, o_done, 1);
    tick();
    checkOutput({name, "/idle_valid"}, o_valid, 0);
    checkOutput({name, "/idle_busy"}, o_busy, 0);
    o_ready = 1'b0;
    if (o_busy) pulseReset();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; kmode = 1'b0; chn = '0;
    in_valid = 1'b0; in_ifm = '0; in_wgt = '0; o_ready = 1'b0;

    vecs[0] = '{0, 1,    1,    2, 0,  0,         8};
    vecs[1] = '{1, 2,    1,   -1, 0,  0,       -72};
    vecs[2] = '{0, 3,   -3,    5, 5, 30,      -180};
    vecs[3] = '{1, 1,  127,  127, 2, 20,    580644};
    vecs[4] = '{0, 2, -128, -128, 1,  0,    131072};
    vecs[5] = '{1, 255, 127,  127, 0,  0, 148064220};

    repeat (2) tick();
    checkOutput("reset/in_ready", in_ready, 0);
    checkOutput("reset/o_valid", o_valid, 0);
    checkOutput("reset/o_psum", o_psum, 0);
    checkOutput("reset/o_busy", o_busy, 0);
    checkOutput("reset/o_done", o_done, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].kmode, vecs[v].chn, 1'b0, vecs[v].ifmVal, vecs[v].wgtVal,
                    vecs[v].hold, vecs[v].gapPct, -1, 1'b1, vecs[v].expRaw,
                    $sformatf("vec%0d", v));
    end

    // A start with zero channel groups must leave the block idle
    run = 1'b1; kmode = 1'b1; chn = '0;
    tick();
    run = 1'b0;
    checkOutput("chn0/busy", o_busy, 0);
    checkOutput("chn0/in_ready", in_ready, 0);

    applyStimulus(1'b1, 1, 1'b1, 0, 0, 1, 0, 3, 1'b0, 0, "mid_start");

    // Abort a 3x3 job after four beats and confirm nothing is ever produced for it
    run = 1'b1; kmode = 1'b1; chn = 8'd1;
    tick();
    run = 1'b0;
    in_valid = 1'b1; in_ifm = {4{8'd1}}; in_wgt = {4{8'd1}};
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort/in_ready", in_ready, 0);
    checkOutput("abort/o_valid", o_valid, 0);
    checkOutput("abort/o_psum", o_psum, 0);
    checkOutput("abort/o_busy", o_busy, 0);
    checkOutput("abort/o_done", o_done, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();
    checkOutput("abort/no_result", o_valid, 0);
    applyStimulus(1'b0, 1, 1'b0, 2, 3, 0, 0, -1, 1'b1, 24, "post_abort");

    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'($urandom_range(1)), $urandom_range(1, 6), 1'b1, 0, 0,
                    $urandom_range(3), $urandom_range(40), -1, 1'b0, 0,
                    $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_pe_mac.md
CONV_PE_MAC -- requirements
Module: conv_pe_mac

Interface
REQ-001 SHALL have parameter W_DATA, 8, signed IFM/weight element width.
REQ-002 SHALL have parameter LANES, 4 (IFM_BUFFER_CNT), channels consumed per input beat.
REQ-003 SHALL have parameter W_ACC, 32, accumulator/output width.
REQ-004 SHALL have parameter W_CHANNEL, as controller_params.vh, width of channel-group count.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port c_ctrl_data_run  input  1  start pulse, sampled only in IDLE.
REQ-008 SHALL have port c_kmode  input  1  kernel mode latched at start; 0 = 1x1 (1 tap), 1 = 3x3 (9 taps).
REQ-009 SHALL have port c_chn  input  W_CHANNEL  number of LANES-wide channel groups, latched at start.
REQ-010 SHALL have ports in_valid input 1, in_ready output 1  beat handshake; transfer when both high.
REQ-011 SHALL have ports in_ifm, in_wgt  input  LANES*W_DATA  packed signed lanes, lane 0 in LSBs.
REQ-012 SHALL have ports o_valid output 1, o_ready input 1  result handshake.
REQ-013 SHALL have port o_psum  output  W_ACC  accumulated partial sum.
REQ-014 SHALL have ports o_busy output 1 (state != IDLE), o_done output 1 (one-cycle pulse on result transfer).

Function
REQ-015 SHALL implement states IDLE, ACC, DRAIN, OUT.
REQ-016 IDLE->ACC on c_ctrl_data_run=1 with c_chn!=0; latch beat total N = taps*c_chn; clear accumulator.
REQ-017 Start with c_chn=0 SHALL be ignored (remain IDLE, no outputs change).
REQ-018 Start while not IDLE SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in ACC with accepted beats < N; 0 in all other states.
REQ-020 Each accepted beat: per-lane signed W_DATA x W_DATA products registered in stage 1 (cycle t+1).
REQ-021 Stage 2 (cycle t+2): sign-extended sum of LANES products added into accumulator.
REQ-022 Gaps in in_valid SHALL stall accumulation without losing or duplicating beats.
REQ-023 ACC->DRAIN the cycle after the N-th beat transfers; DRAIN->OUT once stage 2 holds the final sum; o_valid rises exactly 3 cycles after the N-th beat's transfer cycle.
REQ-024 In OUT, o_valid=1 and o_psum SHALL be held stable until o_ready=1; OUT->IDLE on transfer, o_done pulses that same cycle.
REQ-025 Accumulator arithmetic SHALL wrap modulo 2^W_ACC; no saturation.
REQ-026 Back-to-back: start accepted in the cycle after OUT->IDLE.

Reset
REQ-027 rst=1 SHALL force IDLE regardless of state, clear accumulator, pipeline valids and beat counter.
REQ-028 During/after reset: in_ready=0, o_valid=0, o_psum=0, o_busy=0, o_done=0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result is produced for that job.

Configuration
REQ-030 Macro CONV_PE_RELU_EN defined: o_psum = 0 when accumulator is negative, else accumulator.
REQ-031 Macro CONV_PE_RELU_EN undefined: o_psum = raw signed accumulator; timing identical in both builds.

Verification
REQ-032 kmode=0, chn=1, ifm lanes all 1, wgt all 2, o_ready=1 -> o_psum=8, o_valid 3 cycles after beat, o_done pulse.
REQ-033 kmode=1, chn=2, 18 beats ifm=1, wgt=-1 -> o_psum=-72 (0 with CONV_PE_RELU_EN); in_ready drops after 18th beat.
REQ-034 o_ready held 0 for 5 cycles in OUT -> o_valid and o_psum stable, in_ready=0, o_done only on release.
REQ-035 Start with chn=0 -> o_busy stays 0; start pulse during ACC -> ignored, result matches original job.
REQ-036 rst asserted after 4 of 9 beats -> all outputs 0 next cycle; fresh 1x1 job then yields correct sum.
REQ-037 ifm=127, wgt=127 all lanes, kmode=1, chn=max -> o_psum equals reference sum modulo 2^W_ACC.
